// File: rtl/cpu_pkg.sv
// Shared CPU definitions: condition codes, PSR layout and flag-related types.
// Used by the flag/condition unit and the branch unit.
// No logic lives here.
package cpu_pkg;

    localparam int COND_W = 4;
    localparam int PSR_W  = 5;

    typedef logic [COND_W-1:0] cond_t;
    typedef logic [PSR_W-1:0]  psr_t;

    localparam cond_t COND_EQ = 4'b0000;
    localparam cond_t COND_NE = 4'b0001;
    localparam cond_t COND_CS = 4'b0010;
    localparam cond_t COND_CC = 4'b0011;
    localparam cond_t COND_HI = 4'b0100;
    localparam cond_t COND_LS = 4'b0101;
    localparam cond_t COND_GT = 4'b0110;
    localparam cond_t COND_LE = 4'b0111;
    localparam cond_t COND_FS = 4'b1000;
    localparam cond_t COND_FC = 4'b1001;
    localparam cond_t COND_LO = 4'b1010;
    localparam cond_t COND_HS = 4'b1011;
    localparam cond_t COND_LT = 4'b1100;
    localparam cond_t COND_GE = 4'b1101;
    localparam cond_t COND_UC = 4'b1110;
    localparam cond_t COND_NV = 4'b1111;

    localparam int PSR_C = 0;
    localparam int PSR_L = 1;
    localparam int PSR_F = 2;
    localparam int PSR_Z = 3;
    localparam int PSR_N = 4;

endpackage

// File: rtl/cond_eval.sv
// Evaluates a 4-bit condition code against a PSR value.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no handshake, callers own any flow control.
module cond_eval
    import cpu_pkg::*;
(
    input  logic [COND_W-1:0] cond,
    input  logic [PSR_W-1:0]  psr,
    output logic              cond_true
);

    logic flag_c;
    logic flag_l;
    logic flag_f;
    logic flag_z;
    logic flag_n;

    assign flag_c = psr[PSR_C];
    assign flag_l = psr[PSR_L];
    assign flag_f = psr[PSR_F];
    assign flag_z = psr[PSR_Z];
    assign flag_n = psr[PSR_N];

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            COND_EQ: cond_true = flag_z;
            COND_NE: cond_true = !flag_z;
            COND_CS: cond_true = flag_c;
            COND_CC: cond_true = !flag_c;
            COND_HI: cond_true = flag_l;
            COND_LS: cond_true = !flag_l;
            COND_GT: cond_true = flag_n;
            COND_LE: cond_true = !flag_n;
            COND_FS: cond_true = flag_f;
            COND_FC: cond_true = !flag_f;
            // Unsigned/signed "strictly less" are neither greater nor equal.
            COND_LO: cond_true = !flag_l && !flag_z;
            COND_HS: cond_true = flag_l || flag_z;
            COND_LT: cond_true = !flag_n && !flag_z;
            COND_GE: cond_true = flag_n || flag_z;
            COND_UC: cond_true = 1'b1;
            COND_NV: cond_true = 1'b0;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_cond_unit.sv
// PSR flag register with per-bit write enables, plus a condition-query result stage.
// Latency: PSR write and query result both visible one cycle after the edge.
// Backpressure: one-entry output register; req_ready = !res_valid | res_ready.
module flag_cond_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAGW  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_c,
    input  logic              alu_l,
    input  logic              alu_f,
    input  logic              alu_z,
    input  logic              alu_n,
    input  logic [PSR_W-1:0]  flag_we,
    input  logic              psr_load,
    input  logic [PSR_W-1:0]  psr_load_data,
    output logic [PSR_W-1:0]  psr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [COND_W-1:0] req_cond,
    input  logic [TAGW-1:0]   req_tag,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_true,
    output logic [WIDTH-1:0]  res_word,
    output logic [TAGW-1:0]   res_tag
);

    psr_t       psr_q;
    psr_t       psr_next;
    psr_t       alu_flags;
    logic       eval_true;
    logic       req_accept;

    assign alu_flags[PSR_C] = alu_c;
    assign alu_flags[PSR_L] = alu_l;
    assign alu_flags[PSR_F] = alu_f;
    assign alu_flags[PSR_Z] = alu_z;
    assign alu_flags[PSR_N] = alu_n;

    // A whole-PSR load (LPR) wins over any per-bit ALU flag write.
    always_comb begin
        psr_next = psr_q;
        if (psr_load) begin
            psr_next = psr_load_data;
        end else begin
            for (int i = 0; i < PSR_W; i++) begin
                if (flag_we[i]) begin
                    psr_next[i] = alu_flags[i];
                end
            end
        end
    end

    // Queries see psr_next so a flag write and a dependent branch can share a cycle.
    cond_eval u_cond_eval (
        .cond      (req_cond),
        .psr       (psr_next),
        .cond_true (eval_true)
    );

    assign req_ready  = !res_valid || res_ready;
    assign req_accept = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            psr_q     <= '0;
            res_valid <= 1'b0;
            res_true  <= 1'b0;
            res_word  <= '0;
            res_tag   <= '0;
        end else begin
            psr_q <= psr_next;
            if (req_accept) begin
                res_valid <= 1'b1;
                res_true  <= eval_true;
                res_word  <= WIDTH'(eval_true);
                res_tag   <= req_tag;
            end else if (res_ready) begin
                // Data fields keep their last values once consumed.
                res_valid <= 1'b0;
            end
        end
    end

    assign psr = psr_q;

endmodule

// File: tb/tb_flag_cond_unit.sv
// Self-checking bench for flag_cond_unit: scoreboard of expected query results,
// plus a reference PSR model and an independent condition-table function.
module tb_flag_cond_unit;

    localparam int WIDTH = 16;
    localparam int TAGW  = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             alu_c, alu_l, alu_f, alu_z, alu_n;
    logic [4:0]       flag_we;
    logic             psr_load;
    logic [4:0]       psr_load_data;
    logic [4:0]       psr;
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_cond;
    logic [TAGW-1:0]  req_tag;
    logic             res_valid;
    logic             res_ready;
    logic             res_true;
    logic [WIDTH-1:0] res_word;
    logic [TAGW-1:0]  res_tag;

    typedef struct packed {
        logic            t;
        logic [TAGW-1:0] tag;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [4:0]  ref_psr;
    int          compared   = 0;
    int          mismatched = 0;

    always #5 clk = ~clk;

    flag_cond_unit #(.WIDTH(WIDTH), .TAGW(TAGW)) dut (
        .clk           (clk),
        .reset         (reset),
        .alu_c         (alu_c),
        .alu_l         (alu_l),
        .alu_f         (alu_f),
        .alu_z         (alu_z),
        .alu_n         (alu_n),
        .flag_we       (flag_we),
        .psr_load      (psr_load),
        .psr_load_data (psr_load_data),
        .psr           (psr),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_cond      (req_cond),
        .req_tag       (req_tag),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_true      (res_true),
        .res_word      (res_word),
        .res_tag       (res_tag)
    );

    // Condition table, PSR bit order {N,Z,F,L,C}.
    function automatic logic ref_eval(input logic [3:0] c, input logic [4:0] p);
        logic n, z, f, l, cy;
        {n, z, f, l, cy} = p;
        case (c)
            4'd0:    return z;
            4'd1:    return !z;
            4'd2:    return cy;
            4'd3:    return !cy;
            4'd4:    return l;
            4'd5:    return !l;
            4'd6:    return n;
            4'd7:    return !n;
            4'd8:    return f;
            4'd9:    return !f;
            4'd10:   return !l && !z;
            4'd11:   return l || z;
            4'd12:   return !n && !z;
            4'd13:   return n || z;
            4'd14:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        {alu_c, alu_l, alu_f, alu_z, alu_n} = '0;
        flag_we       = '0;
        psr_load      = 1'b0;
        psr_load_data = '0;
        req_valid     = 1'b0;
        req_cond      = '0;
        req_tag       = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        res_ready = 1'b0;
        reset     = 1'b1;
        step();
        step();
        reset = 1'b0;
        ref_psr = '0;
        compared++; if (psr !== 5'b0) begin mismatched++; $display("FAIL reset_psr: got %b expected 00000", psr); end
        compared++; if (res_valid !== 1'b0) begin mismatched++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
        compared++; if (res_true !== 1'b0) begin mismatched++; $display("FAIL reset_res_true: got %b expected 0", res_true); end
        compared++; if (res_word !== '0) begin mismatched++; $display("FAIL reset_res_word: got %h expected 0000", res_word); end
        compared++; if (res_tag !== '0) begin mismatched++; $display("FAIL reset_res_tag: got %h expected 0", res_tag); end
        compared++; if (req_ready !== 1'b1) begin mismatched++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    endtask

    task automatic test_flag_write();
        flag_we = 5'b00001;
        alu_c   = 1'b1;
        alu_z   = 1'b1;   // enable clear: must not land
        step();
        idle_inputs();
        ref_psr = 5'b00001;
        compared++; if (psr !== ref_psr) begin mismatched++; $display("FAIL flag_write_psr: got %b expected %b", psr, ref_psr); end
    endtask

    task automatic test_bypass();
        res_ready = 1'b1;
        flag_we   = 5'b01000;
        alu_z     = 1'b1;
        req_valid = 1'b1;
        req_cond  = 4'b0000;
        req_tag   = 4'd5;
        ref_psr[3] = 1'b1;
        sb.push_back('{t: ref_eval(4'b0000, ref_psr), tag: 4'd5});
        step();
        idle_inputs();
        compared++; if (res_valid !== 1'b1) begin mismatched++; $display("FAIL bypass_valid: got %b expected 1", res_valid); end
        compared++; if (psr !== ref_psr) begin mismatched++; $display("FAIL bypass_psr: got %b expected %b", psr, ref_psr); end
        if (sb.size() == 0) begin
            compared++; mismatched++; $display("FAIL bypass_sb: scoreboard empty");
        end else begin
            e = sb.pop_front();
            compared++; if (res_true !== e.t) begin mismatched++; $display("FAIL bypass_true: got %b expected %b", res_true, e.t); end
            compared++; if (res_word !== WIDTH'(e.t)) begin mismatched++; $display("FAIL bypass_word: got %h expected %h", res_word, WIDTH'(e.t)); end
            compared++; if (res_tag !== e.tag) begin mismatched++; $display("FAIL bypass_tag: got %h expected %h", res_tag, e.tag); end
        end
        step();
        compared++; if (res_valid !== 1'b0) begin mismatched++; $display("FAIL bypass_drain: got %b expected 0", res_valid); end
    endtask

    task automatic test_sweep();
        res_ready = 1'b1;
        for (int p = 0; p < 32; p++) begin
            for (int c = 0; c < 16; c++) begin
                psr_load      = 1'b1;
                psr_load_data = 5'(p);
                flag_we       = 5'b11111;
                req_valid     = 1'b1;
                req_cond      = 4'(c);
                req_tag       = 4'(c);
                ref_psr       = 5'(p);
                sb.push_back('{t: ref_eval(4'(c), 5'(p)), tag: 4'(c)});
                step();
                compared++; if (res_valid !== 1'b1) begin mismatched++; $display("FAIL sweep_valid p=%0d c=%0d: got %b expected 1", p, c, res_valid); end
                if (sb.size() == 0) begin
                    compared++; mismatched++; $display("FAIL sweep_sb p=%0d c=%0d: scoreboard empty", p, c);
                end else begin
                    e = sb.pop_front();
                    compared++; if (res_true !== e.t) begin mismatched++; $display("FAIL sweep_true p=%b c=%b: got %b expected %b", 5'(p), 4'(c), res_true, e.t); end
                    compared++; if (res_word !== WIDTH'(e.t)) begin mismatched++; $display("FAIL sweep_word p=%0d c=%0d: got %h expected %h", p, c, res_word, WIDTH'(e.t)); end
                    compared++; if (res_tag !== e.tag) begin mismatched++; $display("FAIL sweep_tag p=%0d c=%0d: got %h expected %h", p, c, res_tag, e.tag); end
                end
            end
        end
        idle_inputs();
        step();
        compared++; if (psr !== ref_psr) begin mismatched++; $display("FAIL sweep_psr: got %b expected %b", psr, ref_psr); end
    endtask

    task automatic test_backpressure();
        logic             cap_true;
        logic [WIDTH-1:0] cap_word;
        logic [TAGW-1:0]  cap_tag;
        res_ready = 1'b0;
        req_valid = 1'b1;
        req_cond  = 4'b1110;
        req_tag   = 4'd7;
        sb.push_back('{t: ref_eval(4'b1110, ref_psr), tag: 4'd7});
        step();
        compared++; if (res_valid !== 1'b1) begin mismatched++; $display("FAIL bp_first_valid: got %b expected 1", res_valid); end
        if (sb.size() == 0) begin
            compared++; mismatched++; $display("FAIL bp_first_sb: scoreboard empty");
        end else begin
            e = sb.pop_front();
            compared++; if (res_true !== e.t || res_tag !== e.tag) begin mismatched++; $display("FAIL bp_first_data: got %b/%h expected %b/%h", res_true, res_tag, e.t, e.tag); end
        end
        cap_true = res_true;
        cap_word = res_word;
        cap_tag  = res_tag;
        req_cond = 4'b0000;
        req_tag  = 4'd9;
        for (int i = 0; i < 3; i++) begin
            compared++; if (req_ready !== 1'b0) begin mismatched++; $display("FAIL bp_ready_%0d: got %b expected 0", i, req_ready); end
            flag_we = 5'b01000;
            alu_z   = !ref_psr[3];
            ref_psr[3] = alu_z;
            step();
            compared++; if (res_valid !== 1'b1 || res_true !== cap_true || res_word !== cap_word || res_tag !== cap_tag) begin
                mismatched++;
                $display("FAIL bp_stable_%0d: got v=%b t=%b w=%h tag=%h expected v=1 t=%b w=%h tag=%h",
                         i, res_valid, res_true, res_word, res_tag, cap_true, cap_word, cap_tag);
            end
        end
        flag_we   = '0;
        res_ready = 1'b1;
        #1;
        compared++; if (req_ready !== 1'b1) begin mismatched++; $display("FAIL bp_release_ready: got %b expected 1", req_ready); end
        sb.push_back('{t: ref_eval(4'b0000, ref_psr), tag: 4'd9});
        step();
        idle_inputs();
        compared++; if (res_valid !== 1'b1) begin mismatched++; $display("FAIL bp_second_valid: got %b expected 1", res_valid); end
        if (sb.size() == 0) begin
            compared++; mismatched++; $display("FAIL bp_second_sb: scoreboard empty");
        end else begin
            e = sb.pop_front();
            compared++; if (res_true !== e.t || res_tag !== e.tag) begin mismatched++; $display("FAIL bp_second_data: got %b/%h expected %b/%h", res_true, res_tag, e.t, e.tag); end
        end
        step();
        compared++; if (res_valid !== 1'b0) begin mismatched++; $display("FAIL bp_drain: got %b expected 0", res_valid); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] conds [4];
        conds[0] = 4'd0; conds[1] = 4'd3; conds[2] = 4'd13; conds[3] = 4'd15;
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1;
            req_cond  = conds[i];
            req_tag   = 4'(i + 1);
            sb.push_back('{t: ref_eval(conds[i], ref_psr), tag: 4'(i + 1)});
            step();
            compared++; if (res_valid !== 1'b1) begin mismatched++; $display("FAIL b2b_valid_%0d: got %b expected 1", i, res_valid); end
            if (sb.size() == 0) begin
                compared++; mismatched++; $display("FAIL b2b_sb_%0d: scoreboard empty", i);
            end else begin
                e = sb.pop_front();
                compared++; if (res_tag !== e.tag || res_true !== e.t) begin mismatched++; $display("FAIL b2b_data_%0d: got %b/%h expected %b/%h", i, res_true, res_tag, e.t, e.tag); end
            end
        end
        idle_inputs();
        step();
        compared++; if (res_valid !== 1'b0) begin mismatched++; $display("FAIL b2b_drain: got %b expected 0", res_valid); end
    endtask

    task automatic test_priority_reset();
        res_ready     = 1'b0;
        psr_load      = 1'b1;
        psr_load_data = 5'b10100;
        flag_we       = 5'b11111;
        {alu_c, alu_l, alu_f, alu_z, alu_n} = '0;
        req_valid     = 1'b1;
        req_cond      = 4'd6;
        req_tag       = 4'd3;
        ref_psr       = 5'b10100;
        sb.push_back('{t: ref_eval(4'd6, ref_psr), tag: 4'd3});
        step();
        idle_inputs();
        compared++; if (psr !== 5'b10100) begin mismatched++; $display("FAIL prio_psr: got %b expected 10100", psr); end
        compared++; if (res_valid !== 1'b1) begin mismatched++; $display("FAIL prio_valid: got %b expected 1", res_valid); end
        if (sb.size() == 0) begin
            compared++; mismatched++; $display("FAIL prio_sb: scoreboard empty");
        end else begin
            e = sb.pop_front();
            compared++; if (res_true !== e.t || res_tag !== e.tag) begin mismatched++; $display("FAIL prio_data: got %b/%h expected %b/%h", res_true, res_tag, e.t, e.tag); end
        end
        reset         = 1'b1;
        psr_load      = 1'b1;
        psr_load_data = 5'b11111;
        flag_we       = 5'b11111;
        {alu_c, alu_l, alu_f, alu_z, alu_n} = '1;
        req_valid     = 1'b1;
        req_cond      = 4'd14;
        req_tag       = 4'd12;
        step();
        reset = 1'b0;
        idle_inputs();
        ref_psr = '0;
        compared++; if (psr !== 5'b0) begin mismatched++; $display("FAIL rst_psr: got %b expected 00000", psr); end
        compared++; if (res_valid !== 1'b0) begin mismatched++; $display("FAIL rst_valid: got %b expected 0", res_valid); end
        compared++; if (res_true !== 1'b0 || res_word !== '0 || res_tag !== '0) begin mismatched++; $display("FAIL rst_data: got %b/%h/%h expected 0/0000/0", res_true, res_word, res_tag); end
        compared++; if (req_ready !== 1'b1) begin mismatched++; $display("FAIL rst_ready: got %b expected 1", req_ready); end
    endtask

    initial begin
        reset = 1'b1;
        res_ready = 1'b0;
        idle_inputs();
        #1;
        test_reset();
        test_flag_write();
        test_bypass();
        test_sweep();
        test_backpressure();
        test_back_to_back();
        test_priority_reset();
        compared++; if (sb.size() !== 0) begin mismatched++; $display("FAIL sb_leftover: got %0d entries expected 0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/flag_cond_unit.md
# flag_cond_unit

Holds the processor status register (PSR) flags produced by the 16-bit ALU and evaluates branch, jump and Scond conditions against them. It is the consumer side of the ALU flag interface. Flags are written with per-bit enables. Condition queries enter through a valid/ready handshake and return a registered result one cycle later. The unit sits between the ALU/writeback stage and the fetch/branch and register-writeback logic.

## Interface
- `WIDTH`, 16, datapath width of the Scond result word
- `TAGW`, 4, width of the pass-through destination tag (register index)
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `alu_c`, `alu_l`, `alu_f`, `alu_z`, `alu_n` in 1 each: flag values from the ALU.
- `flag_we` in 5: per-bit write enables, ordered {N,Z,F,L,C}.
- `psr_load` in 1: load the whole PSR from `psr_load_data` (LPR).
- `psr_load_data` in 5: {N,Z,F,L,C}.
- `psr` out 5: current registered PSR, {N,Z,F,L,C}.
- `req_valid` in 1 / `req_ready` out 1: query handshake.
- `req_cond` in 4: condition code.
- `req_tag` in TAGW: opaque tag, returned with the result.
- `res_valid` out 1 / `res_ready` in 1: result handshake.
- `res_true` out 1: condition outcome.
- `res_word` out WIDTH: zero-extended `res_true` (Scond value).
- `res_tag` out TAGW: tag of the query.

## Operation
- PSR update, each cycle:
  - `psr_load` = 1: PSR ← `psr_load_data`. `flag_we` is ignored in that cycle.
  - Otherwise, each bit with its `flag_we` bit set takes the matching `alu_*` value. Bits with a clear enable hold.
- `psr_next` is the value the PSR will hold after the current edge.
- Condition evaluation uses `psr_next`, not `psr`. This bypass lets a query issued in the same cycle as a flag write see the new flags.
- Condition codes:
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 HI: L
  - 0101 LS: !L
  - 0110 GT: N
  - 0111 LE: !N
  - 1000 FS: F
  - 1001 FC: !F
  - 1010 LO: !L & !Z
  - 1011 HS: L | Z
  - 1100 LT: !N & !Z
  - 1101 GE: N | Z
  - 1110 UC: 1
  - 1111: reserved, always 0
- Result stage is a one-entry output register.
- `req_ready` = !`res_valid` | `res_ready` (combinational).
- On accept (`req_valid` & `req_ready`) at an edge:
  - `res_valid` ← 1
  - `res_true` ← eval(`req_cond`, `psr_next`)
  - `res_word` ← {WIDTH-1 zeros, `res_true`}
  - `res_tag` ← `req_tag`
- On `res_valid` & `res_ready` with no accept: `res_valid` ← 0. The data fields hold their last values.
- Accept and consume in the same cycle: the new result replaces the old one and `res_valid` stays 1. This gives back-to-back throughput of one query per cycle.
- While `res_valid` & !`res_ready`, all `res_*` outputs are stable. Later PSR writes do not alter a captured result.

## Timing
- Reset values: `psr` = 0, `res_valid` = 0, `res_true` = 0, `res_word` = 0, `res_tag` = 0.
- `req_ready` is 1 in the first cycle after reset.
- Reset asserted mid-operation clears any pending result (it is dropped) and the PSR at the next edge. Simultaneous `psr_load`/`flag_we`/`req_valid` in the reset cycle have no effect.
- Latency:
  - PSR write visible on `psr` 1 cycle after the edge.
  - Query result visible on `res_*` 1 cycle after accept.
- `req_ready` depends combinationally only on `res_valid` and `res_ready`, never on `req_valid`. This avoids combinational loops.
- No other combinational path from inputs to outputs.

## Structure
- Shared package `cpu_pkg` holds:
  - 4-bit condition-code localparams (`COND_EQ` … `COND_UC`, `COND_NV`).
  - PSR bit indices `PSR_C`=0, `PSR_L`=1, `PSR_F`=2, `PSR_Z`=3, `PSR_N`=4.
- Sub-module `cond_eval`: purely combinational (cond, psr) → true. It is reused by the branch unit.
- `flag_cond_unit` contains the PSR register, the bypass mux and the output register/handshake.

## Test plan
- Reset, then write flags with `flag_we`=00001, `alu_c`=1:
  - `psr` = 00001 one cycle later.
  - Other bits remain 0.
- Same-cycle bypass: `flag_we`=01000, `alu_z`=1, `req_valid`=1, `req_cond`=0000, `req_tag`=5:
  - Next cycle `res_valid`=1, `res_true`=1, `res_word`=0x0001, `res_tag`=5.
- Sweep all 16 codes over all 32 PSR values via `psr_load`:
  - `res_true` matches the table in Operation.
  - 1110 always 1; 1111 always 0.
- Backpressure: hold `res_ready`=0 after one accept, then issue a second query.
  - `req_ready`=0 and `res_*` stable for 3 cycles.
  - Raise `res_ready`: the second query is accepted that cycle and its result appears next cycle.
- Back-to-back: `res_ready`=1, queries on 4 consecutive cycles with tags 1,2,3,4:
  - Results appear on 4 consecutive cycles with tags 1,2,3,4 and `res_valid` continuously 1.
- Priority and reset:
  - `psr_load`=1 with data 10100 and `flag_we`=11111 with all `alu_*`=0 → `psr`=10100.
  - Then `reset` with `res_valid`=1 pending → all outputs 0 next cycle.
